regfile_fifo_ctrl: RTL and testbench

Pointer/occupancy controller that sequences the RegFile register file as a circular FIFO. It accepts push/pop requests from a producer and a consumer, and drives the RegFile write enable, read enable, write address and read address. It reports full/empty/count status and sticky error flags. It sits beside RegFile; DataIn/DataOut connect directly between the FIFO users and RegFile, not through this block.

---
 rtl/regfile_fifo_ctrl.sv | 79 +++++++
 tb/tb_regfile_fifo_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/regfile_fifo_ctrl.sv
// Pointer/occupancy controller that runs an external RegFile as a circular FIFO.
// Drives RegFile write/read enables and addresses, and reports occupancy status and sticky error flags.
module regfile_fifo_ctrl #(
    parameter int ws     = 4,
    parameter int depth  = 8,
    parameter int as     = $clog2(depth),
    parameter int af_lvl = depth - 1,
    parameter int ae_lvl = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    output logic          wr,
    output logic          rd,
    output logic [as-1:0] AddrWr,
    output logic [as-1:0] AddrRd,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [as:0]   count,
    output logic          overflow,
    output logic          underflow
);

    if (depth < 2 || ws < 1) begin : g_bad_cfg
        $error("regfile_fifo_ctrl: depth must be >= 2 and ws >= 1");
    end

    localparam logic [as-1:0] LAST_ADDR = as'(depth - 1);
    localparam logic [as:0]   FULL_CNT  = (as + 1)'(depth);
    localparam logic [as:0]   AF_CNT    = (as + 1)'(af_lvl);
    localparam logic [as:0]   AE_CNT    = (as + 1)'(ae_lvl);

    logic push_ok;
    logic pop_ok;

    // Requests are qualified on pre-edge status; reset masks both enables.
    assign push_ok = push & ~full & ~reset;
    assign pop_ok  = pop & ~empty & ~reset;
    assign wr      = push_ok;
    assign rd      = pop_ok;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            AddrWr    <= '0;
            AddrRd    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Explicit wrap so non-power-of-two depths stay inside the RegFile.
            if (push_ok) begin
                AddrWr <= (AddrWr == LAST_ADDR) ? '0 : AddrWr + as'(1);
            end
            if (pop_ok) begin
                AddrRd <= (AddrRd == LAST_ADDR) ? '0 : AddrRd + as'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (as + 1)'(1);
                2'b01:   count <= count - (as + 1)'(1);
                default: count <= count;
            endcase
            if (push & full) begin
                overflow <= 1'b1;
            end
            if (pop & empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_fifo_ctrl.sv
// Self-checking bench for regfile_fifo_ctrl: a bench-side RegFile plus a queue-based FIFO model.
module tb_regfile_fifo_ctrl;

    localparam int WS    = 4;
    localparam int DEPTH = 8;
    localparam int AS    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          wr, rd;
    logic [AS-1:0] AddrWr, AddrRd;
    logic          full, empty, almost_full, almost_empty;
    logic [AS:0]   count;
    logic          overflow, underflow;

    logic [WS-1:0] data_in = '0;
    logic [WS-1:0] data_out;
    logic [WS-1:0] rf_mem [DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    // Model state: stored words in order, plus accepted push/pop totals since reset.
    logic [WS-1:0] mq[$];
    int            n_push_acc = 0;
    int            n_pop_acc  = 0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    regfile_fifo_ctrl #(.ws(WS), .depth(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .wr           (wr),
        .rd           (rd),
        .AddrWr       (AddrWr),
        .AddrRd       (AddrRd),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Stand-in RegFile: write at the edge, combinational read, high-Z when not read.
    always @(posedge clk) begin
        if (wr === 1'b1) rf_mem[AddrWr] <= data_in;
    end
    assign data_out = (rd === 1'b1) ? rf_mem[AddrRd] : 'z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit p, input bit q, input bit r, input logic [WS-1:0] d);
        bit m_full, m_empty, exp_wr, exp_rd;
        int sz;
        @(negedge clk);
        push = p; pop = q; reset = r; data_in = d;
        sz      = mq.size();
        m_full  = (sz == DEPTH);
        m_empty = (sz == 0);
        exp_wr  = p && !m_full && !r;
        exp_rd  = q && !m_empty && !r;
        #1;
        chk("wr", 32'(wr), 32'(exp_wr));
        chk("rd", 32'(rd), 32'(exp_rd));
        if (exp_rd) chk("data_out", 32'(data_out), 32'(mq[0]));
        @(posedge clk);
        if (r) begin
            mq.delete();
            n_push_acc = 0; n_pop_acc = 0;
            m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (p && m_full)  m_ovf = 1'b1;
            if (q && m_empty) m_unf = 1'b1;
            if (exp_rd) begin void'(mq.pop_front()); n_pop_acc++; end
            if (exp_wr) begin mq.push_back(d); n_push_acc++; end
        end
        #1;
        sz = mq.size();
        chk("count",        32'(count),        32'(sz));
        chk("full",         32'(full),         32'(sz == DEPTH));
        chk("empty",        32'(empty),        32'(sz == 0));
        chk("almost_full",  32'(almost_full),  32'(sz >= DEPTH - 1));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= 1));
        chk("AddrWr",       32'(AddrWr),       32'(n_push_acc % DEPTH));
        chk("AddrRd",       32'(AddrRd),       32'(n_pop_acc % DEPTH));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, then idle.
        step(0, 0, 1, '0);
        step(1, 1, 1, 4'hA);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);

        // Fill with 1..8, then one push too many.
        for (int i = 1; i <= 9; i++) step(1, 0, 0, WS'(i));
        // Drain in order, then one pop too many.
        for (int i = 0; i < 9; i++) step(0, 1, 0, '0);

        // Wraparound traffic from a clean start.
        step(0, 0, 1, '0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, WS'(i + 3));
        for (int i = 0; i < 5; i++) step(0, 1, 0, '0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, WS'(i + 9));
        for (int i = 0; i < 6; i++) step(0, 1, 0, '0);

        // Simultaneous push+pop: mid-level, at empty, at full.
        step(0, 0, 1, '0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, WS'(i + 1));
        for (int i = 0; i < 4; i++) step(1, 1, 0, WS'(i + 4));
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
        step(1, 1, 0, 4'hE);
        step(0, 0, 1, '0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, WS'(15 - i));
        step(1, 1, 0, 4'h5);

        // Reset while partially full with a push pending.
        step(0, 0, 1, '0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, WS'(i + 2));
        step(1, 0, 1, 4'h7);
        step(0, 0, 0, '0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 99) < 55),
                 bit'($urandom_range(0, 99) < 50),
                 bit'($urandom_range(0, 99) < 2),
                 WS'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
